// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access : MEM stage of the GenshinMIPS pipeline with the MEM/WB register
//              built in.
//
// Loads and stores (LB/LW/SB/SW) are executed on a single-master, ack-based
// data-SRAM bus. The pipeline is held through stall_req_o while an access is
// outstanding. All other ops pass straight through to WB with one cycle of
// latency.
//
// Optional build macro:
//   MEM_ALIGN_CHECK_EN : LW/SW with a non-zero byte offset issue no bus cycle.
//                        The access completes as an aborted op (WB write
//                        suppressed) and misalign_o pulses for one cycle.
//                        Without the macro the low address bits of LW/SW are
//                        ignored, and the port misalign_o does not exist.
//
// Parameters:
//   TIMEOUT : REQ cycles to wait for bus_ack_i before aborting (1..1023)
//   TO_W    : width of the timeout counter
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   aluop_i                   op from EX
//   mem_addr_i, mem_data_i    byte address / store data from EX
//   waddr_i, we_i, wdata_i    ALU write-back triple from EX
//   waddr_o, we_o, wdata_o    registered WB triple
//   stall_req_o               combinational pipeline hold request
//   bus_req_o .. bus_wdata_o  registered bus request, direction, word
//                             address, byte enables, write data
//   bus_rdata_i, bus_ack_i    read data and one-cycle completion strobe
//   bus_err_o                 one-cycle pulse on bus timeout
//   misalign_o                (MEM_ALIGN_CHECK_EN only) misaligned LW/SW pulse
// -----------------------------------------------------------------------------
module mem_access #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic [4:0]  waddr_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   output logic [4:0]  waddr_o,
   output logic        we_o,
   output logic [31:0] wdata_o,
   output logic        stall_req_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        misalign_o
`endif
);

   localparam logic [7:0] EXE_LB_OP = 8'b1110_0000;
   localparam logic [7:0] EXE_LW_OP = 8'b1110_0011;
   localparam logic [7:0] EXE_SB_OP = 8'b1110_1000;
   localparam logic [7:0] EXE_SW_OP = 8'b1110_1011;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   // Selects byte[8*off +: 8] of a word and sign-extends it to 32 bits.
   function automatic logic [31:0] sext_byte(input logic [31:0] word,
                                             input logic [1:0]  off);
      logic [7:0] b;
      b = word[{off, 3'b000} +: 8];
      return {{24{b[7]}}, b};
   endfunction

   logic [1:0]      state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            ld_q, ld_d;            // latched op is a load
   logic            byte_q, byte_d;        // latched op is byte-wide
   logic [1:0]      off_q, off_d;          // latched byte offset
   logic [4:0]      waddr_lat_q, waddr_lat_d;
   logic            we_lat_q, we_lat_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            abort_q, abort_d;

   logic [4:0]      waddr_q, waddr_d;
   logic            we_q, we_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            bus_req_q, bus_req_d;
   logic            bus_we_q, bus_we_d;
   logic [31:0]     bus_addr_q, bus_addr_d;
   logic [3:0]      bus_be_q, bus_be_d;
   logic [31:0]     bus_wdata_q, bus_wdata_d;
   logic            bus_err_q, bus_err_d;
`ifdef MEM_ALIGN_CHECK_EN
   logic            misalign_q, misalign_d;
`endif

   logic is_lb_s, is_lw_s, is_sb_s, is_sw_s, is_mem_s, misalign_s, stall_s;

   // Op decode of the incoming EX op.
   always_comb begin
      is_lb_s  = (aluop_i == EXE_LB_OP);
      is_lw_s  = (aluop_i == EXE_LW_OP);
      is_sb_s  = (aluop_i == EXE_SB_OP);
      is_sw_s  = (aluop_i == EXE_SW_OP);
      is_mem_s = is_lb_s | is_lw_s | is_sb_s | is_sw_s;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_s = (is_lw_s | is_sw_s) & (mem_addr_i[1:0] != 2'b00);
`else
      misalign_s = 1'b0;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; an ack in the final REQ cycle wins over timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (is_mem_s) begin
               state_d = misalign_s ? S_DONE : S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (bus_ack_i || (cnt_q == TO_LAST)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_REQ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: stall request and next values of every datapath register.
   always_comb begin
      stall_s      = 1'b0;
      cnt_d        = cnt_q;
      ld_d         = ld_q;
      byte_d       = byte_q;
      off_d        = off_q;
      waddr_lat_d  = waddr_lat_q;
      we_lat_d     = we_lat_q;
      rdata_d      = rdata_q;
      abort_d      = abort_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_be_d     = bus_be_q;
      bus_wdata_d  = bus_wdata_q;
      bus_err_d    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_d   = 1'b0;
`endif
      // WB sees a bubble unless a result retires this cycle.
      waddr_d      = 5'd0;
      we_d         = 1'b0;
      wdata_d      = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (is_mem_s) begin
               stall_s     = 1'b1;
               cnt_d       = {TO_W{1'b0}};
               ld_d        = is_lb_s | is_lw_s;
               byte_d      = is_lb_s | is_sb_s;
               off_d       = mem_addr_i[1:0];
               waddr_lat_d = waddr_i;
               we_lat_d    = we_i;
               abort_d     = 1'b0;
               if (misalign_s) begin
                  abort_d    = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                  misalign_d = 1'b1;
`endif
               end else begin
                  bus_req_d   = 1'b1;
                  bus_we_d    = is_sb_s | is_sw_s;
                  bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                  if (is_lb_s || is_sb_s) begin
                     bus_be_d = 4'b0001 << mem_addr_i[1:0];
                  end else begin
                     bus_be_d = 4'b1111;
                  end
                  if (is_sb_s) begin
                     bus_wdata_d = {4{mem_data_i[7:0]}};
                  end else if (is_sw_s) begin
                     bus_wdata_d = mem_data_i;
                  end else begin
                     bus_wdata_d = 32'd0;
                  end
               end
            end else begin
               waddr_d = waddr_i;
               we_d    = we_i;
               wdata_d = wdata_i;
            end
         end
         S_REQ: begin
            stall_s = 1'b1;
            cnt_d   = cnt_q + TO_W'(1);
            if (bus_ack_i) begin
               rdata_d   = bus_rdata_i;
               bus_req_d = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               abort_d   = 1'b1;
            end else begin
               bus_req_d = 1'b1;
            end
         end
         S_DONE: begin
            waddr_d = waddr_lat_q;
            if (abort_q) begin
               we_d    = 1'b0;
               wdata_d = 32'd0;
            end else if (ld_q) begin
               we_d    = we_lat_q;
               wdata_d = byte_q ? sext_byte(rdata_q, off_q) : rdata_q;
            end else begin
               we_d    = 1'b0;
               wdata_d = 32'd0;
            end
         end
         default: begin
            stall_s = 1'b0;
         end
      endcase
   end

   // Datapath, bus and MEM/WB registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= {TO_W{1'b0}};
         ld_q        <= 1'b0;
         byte_q      <= 1'b0;
         off_q       <= 2'b00;
         waddr_lat_q <= 5'd0;
         we_lat_q    <= 1'b0;
         rdata_q     <= 32'd0;
         abort_q     <= 1'b0;
         waddr_q     <= 5'd0;
         we_q        <= 1'b0;
         wdata_q     <= 32'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
         bus_err_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         ld_q        <= ld_d;
         byte_q      <= byte_d;
         off_q       <= off_d;
         waddr_lat_q <= waddr_lat_d;
         we_lat_q    <= we_lat_d;
         rdata_q     <= rdata_d;
         abort_q     <= abort_d;
         waddr_q     <= waddr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         bus_err_q   <= bus_err_d;
`ifdef MEM_ALIGN_CHECK_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

   // Stall is forced low while reset is asserted, whatever op EX presents.
   assign stall_req_o = rst & stall_s;
   assign waddr_o     = waddr_q;
   assign we_o        = we_q;
   assign wdata_o     = wdata_q;
   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_be_o    = bus_be_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_err_o   = bus_err_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_o  = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access : randomized self-checking bench for mem_access.
// The driver plays EX and the SRAM slave. For every op it writes the expected
// per-cycle outputs (stall, bus request, bus fields, error pulse, WB triple)
// into cycle-indexed tables, derived from the op's timeline: one IDLE cycle,
// then the REQ cycles up to ack/timeout, then DONE, then WB. A single negedge
// process compares the DUT against those tables.
// -----------------------------------------------------------------------------
module tb_mem_access;

   localparam int TO   = 4;
   localparam int NCYC = 8192;

   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] OP_ADD = 8'b0010_0000;
   localparam logic [7:0] OP_OR  = 8'b0010_0101;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  aluop_i = 8'd0;
   logic [31:0] mem_addr_i = 32'd0, mem_data_i = 32'd0, wdata_i = 32'd0;
   logic [4:0]  waddr_i = 5'd0;
   logic        we_i = 1'b0;
   logic [31:0] bus_rdata_i = 32'd0;
   logic        bus_ack_i = 1'b0;
   logic [4:0]  waddr_o;
   logic        we_o, stall_req_o, bus_req_o, bus_we_o, bus_err_o;
   logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign_o;
`endif

   mem_access #(.TIMEOUT(TO), .TO_W(10)) dut (
      .clk(clk), .rst(rst),
      .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
      .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
      .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
      .stall_req_o(stall_req_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
`ifdef MEM_ALIGN_CHECK_EN
      , .misalign_o(misalign_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected-value tables, indexed by cycle number.
   bit          e_chk [NCYC];
   bit          e_stall [NCYC];
   bit          e_req [NCYC];
   bit          e_err [NCYC];
   bit          e_bus [NCYC];
   bit          e_bwe [NCYC];
   logic [31:0] e_baddr [NCYC];
   logic [3:0]  e_be [NCYC];
   bit          e_bwd_chk [NCYC];
   logic [31:0] e_bwd [NCYC];
   bit          e_wb [NCYC];
   bit          e_we [NCYC];
   bit          e_wa_chk [NCYC];
   logic [4:0]  e_wa [NCYC];
   bit          e_wd_chk [NCYC];
   logic [31:0] e_wd [NCYC];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare process: DUT outputs against the tables, sampled on negedge.
   always @(negedge clk) begin
      if (cyc < NCYC) begin
         if (e_chk[cyc]) begin
            check32("stall_req_o", {31'd0, stall_req_o}, {31'd0, e_stall[cyc]});
            check32("bus_req_o",   {31'd0, bus_req_o},   {31'd0, e_req[cyc]});
            check32("bus_err_o",   {31'd0, bus_err_o},   {31'd0, e_err[cyc]});
            if (e_bus[cyc]) begin
               check32("bus_we_o",   {31'd0, bus_we_o}, {31'd0, e_bwe[cyc]});
               check32("bus_addr_o", bus_addr_o, e_baddr[cyc]);
               check32("bus_be_o",   {28'd0, bus_be_o}, {28'd0, e_be[cyc]});
               if (e_bwd_chk[cyc]) check32("bus_wdata_o", bus_wdata_o, e_bwd[cyc]);
            end
         end
         if (e_wb[cyc]) begin
            check32("we_o", {31'd0, we_o}, {31'd0, e_we[cyc]});
            if (e_wa_chk[cyc]) check32("waddr_o", {27'd0, waddr_o}, {27'd0, e_wa[cyc]});
            if (e_wd_chk[cyc]) check32("wdata_o", wdata_o, e_wd[cyc]);
         end
      end
   end

   task automatic expect_ctl(input int c, input bit stall, input bit req, input bit err);
      if (c < NCYC) begin
         e_chk[c] = 1'b1; e_stall[c] = stall; e_req[c] = req; e_err[c] = err;
      end
   endtask

   task automatic expect_wb(input int c, input bit we, input bit wa_chk, input logic [4:0] wa,
                            input bit wd_chk, input logic [31:0] wd);
      if (c < NCYC) begin
         e_wb[c] = 1'b1; e_we[c] = we;
         e_wa_chk[c] = wa_chk; e_wa[c] = wa;
         e_wd_chk[c] = wd_chk; e_wd[c] = wd;
      end
   endtask

   // Runs one op starting in the current cycle (called #1 after a posedge).
   // d = wait cycles before ack; d >= TO means the slave never acks.
   // Returns #1 after the edge that makes the op's WB result visible.
   task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wa, input logic w_e, input logic [31:0] wd,
                        input int d, input logic [31:0] rd);
      bit          mem, ld, byt, tmo;
      int          n;
      logic [31:0] cap, sh, bwd;
      logic [3:0]  be;
      mem = (op == OP_LB) || (op == OP_LW) || (op == OP_SB) || (op == OP_SW);
      ld  = (op == OP_LB) || (op == OP_LW);
      byt = (op == OP_LB) || (op == OP_SB);
      aluop_i = op; mem_addr_i = addr; mem_data_i = data;
      waddr_i = wa; we_i = w_e; wdata_i = wd;
      bus_ack_i = 1'($urandom_range(0, 1));     // ignored outside REQ
      bus_rdata_i = $urandom;
      expect_ctl(cyc, mem, 1'b0, 1'b0);
      if (!mem) begin
         @(posedge clk); #1;
         expect_wb(cyc, w_e, 1'b1, wa, 1'b1, wd);
         return;
      end
      be  = byt ? 4'(1 << addr[1:0]) : 4'hF;
      bwd = byt ? {4{data[7:0]}} : data;
      tmo = (d >= TO);
      n   = tmo ? TO : d + 1;
      cap = 32'd0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         bus_ack_i   = (!tmo && k == n);
         bus_rdata_i = bus_ack_i ? rd : $urandom;
         if (bus_ack_i) cap = rd;
         expect_ctl(cyc, 1'b1, 1'b1, 1'b0);
         if (cyc < NCYC) begin
            e_bus[cyc] = 1'b1; e_bwe[cyc] = !ld;
            e_baddr[cyc] = {addr[31:2], 2'b00}; e_be[cyc] = be;
            e_bwd_chk[cyc] = !ld; e_bwd[cyc] = bwd;
         end
      end
      @(posedge clk); #1;                       // DONE
      bus_ack_i = 1'($urandom_range(0, 1));
      bus_rdata_i = $urandom;
      expect_ctl(cyc, 1'b0, 1'b0, tmo);
      @(posedge clk); #1;                       // WB visible
      sh = cap >> (8 * addr[1:0]);
      if (tmo)
         expect_wb(cyc, 1'b0, 1'b0, wa, 1'b1, 32'd0);
      else if (op == OP_LW)
         expect_wb(cyc, w_e, 1'b1, wa, 1'b1, cap);
      else if (op == OP_LB)
         expect_wb(cyc, w_e, 1'b1, wa, 1'b1, 32'($signed(sh[7:0])));
      else
         expect_wb(cyc, 1'b0, 1'b0, wa, 1'b0, 32'd0);
   endtask

   task automatic rand_op();
      logic [7:0] op;
      case ($urandom_range(0, 5))
         0:       op = OP_ADD;
         1:       op = OP_OR;
         2:       op = OP_LB;
         3:       op = OP_LW;
         4:       op = OP_SB;
         default: op = OP_SW;
      endcase
      do_op(op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
            $urandom_range(0, TO), $urandom);
   endtask

   initial begin
      // Reset with a load presented: every output must stay low.
      aluop_i = OP_LW; mem_addr_i = 32'h8000_0010;
      repeat (2) @(posedge clk);
      #1;
      check32("rst stall_req_o", {31'd0, stall_req_o}, 32'd0);
      check32("rst bus_req_o",   {31'd0, bus_req_o},   32'd0);
      check32("rst bus_err_o",   {31'd0, bus_err_o},   32'd0);
      check32("rst we_o",        {31'd0, we_o},        32'd0);
      check32("rst wdata_o",     wdata_o,              32'd0);
      check32("rst bus_addr_o",  bus_addr_o,           32'd0);
      check32("rst bus_be_o",    {28'd0, bus_be_o},    32'd0);
      rst = 1'b1;

      do_op(OP_ADD, 32'd0, 32'd0, 5'd5, 1'b1, 32'h1234_5678, 0, 32'd0);
      check32("add wdata_o", wdata_o, 32'h1234_5678);
      check32("add waddr_o", {27'd0, waddr_o}, 32'd5);
      check32("add we_o", {31'd0, we_o}, 32'd1);

      do_op(OP_LW, 32'h8000_0104, 32'd0, 5'd7, 1'b1, 32'd0, 0, 32'hDEAD_BEEF);
      check32("lw wdata_o", wdata_o, 32'hDEAD_BEEF);

      do_op(OP_LB, 32'h8000_0003, 32'd0, 5'd8, 1'b1, 32'd0, 1, 32'h80FF_0011);
      check32("lb3 wdata_o", wdata_o, 32'hFFFF_FF80);
      do_op(OP_LB, 32'h8000_0001, 32'd0, 5'd9, 1'b1, 32'd0, 0, 32'h80FF_0011);
      check32("lb1 wdata_o", wdata_o, 32'h0000_0000);

      do_op(OP_SB, 32'h8000_0002, 32'h0000_00A5, 5'd3, 1'b1, 32'd0, 3, 32'd0);
      check32("sb we_o", {31'd0, we_o}, 32'd0);

      do_op(OP_LW, 32'h8000_0200, 32'd0, 5'd4, 1'b1, 32'd0, TO, 32'd0);
      check32("timeout we_o", {31'd0, we_o}, 32'd0);

      // Ack in the last allowed cycle wins over the timeout.
      do_op(OP_LW, 32'h8000_0300, 32'd0, 5'd6, 1'b1, 32'd0, TO - 1, 32'hCAFE_0001);
      check32("late-ack wdata_o", wdata_o, 32'hCAFE_0001);

      for (int i = 0; i < 300; i++) rand_op();

      // Reset in the middle of REQ: bus request and stall fall at once.
      aluop_i = OP_LW; mem_addr_i = 32'h8000_0400; bus_ack_i = 1'b0;
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      @(posedge clk); #1;
      check32("midreq bus_req_o", {31'd0, bus_req_o}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check32("midrst bus_req_o",   {31'd0, bus_req_o},   32'd0);
      check32("midrst stall_req_o", {31'd0, stall_req_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      do_op(OP_LW, 32'h8000_0500, 32'd0, 5'd10, 1'b1, 32'd0, 0, 32'h0BAD_F00D);
      check32("post-rst wdata_o", wdata_o, 32'h0BAD_F00D);

      for (int i = 0; i < 100; i++) rand_op();
      aluop_i = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the GenshinMIPS pipeline, with the MEM/WB register built in.
- Consumes the EX-stage outputs: aluop, mem_addr, mem_data, and the ALU write-back triple waddr/we/wdata.
- Executes LB/LW/SB/SW on a single-master, ack-based data-SRAM bus and holds the pipeline with stall_req_o while an access is outstanding.
- Non-memory ops pass through to WB with 1-cycle latency.

Parameters:
- TIMEOUT, 255, maximum REQ cycles to wait for bus_ack_i before the access is aborted (valid range 1..1023).
- TO_W, 10, width of the timeout counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  one clock; reset is asynchronous and active-low
- aluop_i  in  AluOpBus  op from EX (EXE_LB_OP/LW/SB/SW; anything else is non-memory)
- mem_addr_i  in  32  byte address from EX
- mem_data_i  in  32  store data from EX
- waddr_i  in  RegAddrBus  destination register
- we_i  in  1  register write enable
- wdata_i  in  32  ALU result
- waddr_o  out  RegAddrBus  WB destination (registered)
- we_o  out  1  WB write enable (registered)
- wdata_o  out  32  WB data (registered)
- stall_req_o  out  1  pipeline hold request (combinational)
- bus_req_o  out  1  bus request (registered)
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address, bits[1:0] = 00
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  write data
- bus_rdata_i  in  32  read data, valid with ack
- bus_ack_i  in  1  one-cycle completion strobe
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM goes to IDLE; counter cleared. bus_req_o drops immediately, even mid-access.
- FSM states: IDLE, REQ, DONE.
- IDLE, non-memory op: at the next edge waddr_o/we_o/wdata_o load waddr_i/we_i/wdata_i; stall_req_o=0.
- IDLE, memory op:
  - stall_req_o=1 combinationally in the same cycle.
  - At the edge, register bus_addr_o={mem_addr_i[31:2],2'b00} and set bus_req_o=1.
  - bus_we_o=1 for SB/SW, 0 for LB/LW.
  - bus_be_o=4'b1111 for LW/SW; 4'b0001<<mem_addr_i[1:0] for LB/SB.
  - bus_wdata_o=mem_data_i for SW; {4{mem_data_i[7:0]}} for SB.
  - Go to REQ and clear the counter.
- REQ:
  - stall_req_o=1; bus outputs held stable; counter increments each cycle.
  - bus_ack_i=1: capture bus_rdata_i, drop bus_req_o at the edge, go to DONE.
  - No ack and counter==TIMEOUT-1: drop bus_req_o, pulse bus_err_o for 1 cycle, mark access aborted, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - stall_req_o=0; at the edge load the WB registers, then return to IDLE.
  - LW: wdata_o = captured word.
  - LB: wdata_o = sign-extended byte[8*addr[1:0]+:8].
  - SB/SW: we_o=0.
  - waddr_o=waddr_i; we_o=we_i for loads.
  - Aborted access: we_o=0, wdata_o=0.
- Upstream holds all *_i stable while stall_req_o=1; the block latches addr/op at IDLE and uses the latched copies thereafter.
- Minimum memory-op latency: IDLE→REQ (ack in first REQ cycle)→DONE = 3 cycles, stall high for 2.
- Back-to-back memory ops: the second op is evaluated in IDLE on the cycle after DONE.
- bus_ack_i in IDLE or DONE is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - LW/SW with mem_addr_i[1:0]!=0 issue no bus cycle.
  - FSM goes IDLE→DONE directly, stall_req_o=1 for that IDLE cycle.
  - Output misalign_o pulses 1 for 1 cycle; the WB write is suppressed (we_o=0).
- When not defined:
  - No misalign_o port.
  - Low address bits are ignored for LW/SW; the aligned word is accessed.

Test Plan:
- ADD op, wdata_i=32'h12345678, waddr_i=5, we_i=1 → next edge: wdata_o=32'h12345678, waddr_o=5, we_o=1; stall_req_o never 1.
- LW addr=32'h80000104, ack in first REQ cycle, rdata=32'hDEADBEEF → bus_addr_o=32'h80000104, be=1111, stall 2 cycles, wdata_o=32'hDEADBEEF.
- LB addr=32'h80000003, rdata=32'h80FF0011 → be=1000, wdata_o=32'hFFFFFF80; LB addr=...01 with same rdata → wdata_o=32'h00000000.
- SB addr=32'h80000002, data=32'h000000A5, ack after 3 wait cycles → be=0100, bus_wdata_o=32'hA5A5A5A5, we=1, stall 5 cycles, we_o=0.
- LW with no ack, TIMEOUT=4 → bus_req_o high exactly 4 cycles, bus_err_o 1-cycle pulse, we_o=0.
- rst=0 asserted mid-REQ → bus_req_o and stall_req_o go 0 immediately; after release, the next op starts from IDLE.
